// File: rtl/config_frame_assembler.sv
// config_frame_assembler
//   Consumes the 32-bit word stream from the USB-CDC deframer, parses a frame
//   header, gathers NUM_ROWS data words into one configuration frame and issues
//   a single-cycle frame strobe with column/frame address.
//
//   Optional build macro: CONFIG_FRAME_CHECKSUM_EN
//     defined   : a checksum word (XOR of header and all data words) must follow
//                 the data words; the frame commits only if it matches.
//     undefined : the frame commits on the last data word (1+NUM_ROWS words).
//
//   Handshake: word_write_strobe_i is a valid-only pulse with no ready/back-pressure;
//   every strobed word is consumed in the cycle it is presented. frame_strobe_o
//   and error_o are single-cycle pulses with no acknowledge.
module config_frame_assembler #(
   parameter int NUM_ROWS       = 4,
   parameter int NUM_COLUMNS    = 16,
   parameter int FRAMES_PER_COL = 20,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int FW = NUM_ROWS * 32,
   localparam int CW = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
   localparam int IW = (FRAMES_PER_COL > 1) ? $clog2(FRAMES_PER_COL) : 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          word_write_strobe_i,
   input  logic [31:0]   write_data_i,
   output logic          frame_strobe_o,
   output logic [FW-1:0] frame_data_o,
   output logic [CW-1:0] frame_col_o,
   output logic [IW-1:0] frame_idx_o,
   output logic          busy_o,
   output logic          error_o,
   output logic [1:0]    state_o
);

   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
   // Count value at which one more idle cycle reaches the timeout.
   localparam logic [TW-1:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
   localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t        state;
   logic [FW-1:0] shadow_data;
   logic [CW-1:0] shadow_col;
   logic [IW-1:0] shadow_idx;
   logic [RW-1:0] row_cnt;
   logic [TW-1:0] idle_cnt;
   logic [31:0]   xor_acc;

   logic          hdr_ok;
   logic [FW-1:0] shifted_data;
   logic          timed_out;

   // Header decode, shift-in of the incoming word, and idle timeout detect.
   always_comb begin
      hdr_ok       = (write_data_i[31:24] == 8'hFA)
                  && ({24'd0, write_data_i[23:16]} < $unsigned(NUM_COLUMNS))
                  && ({24'd0, write_data_i[7:0]}   < $unsigned(FRAMES_PER_COL));
      shifted_data = (shadow_data << 32) | FW'(write_data_i);
      timed_out    = TO_EN && (idle_cnt == TO_LAST);
   end

   assign busy_o  = (state != S_IDLE);
   assign state_o = state;

   // Frame assembly FSM with registered frame outputs and status pulses.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state          <= S_IDLE;
         shadow_data    <= '0;
         shadow_col     <= '0;
         shadow_idx     <= '0;
         row_cnt        <= '0;
         idle_cnt       <= '0;
         xor_acc        <= '0;
         frame_strobe_o <= 1'b0;
         frame_data_o   <= '0;
         frame_col_o    <= '0;
         frame_idx_o    <= '0;
         error_o        <= 1'b0;
      end else begin
         frame_strobe_o <= 1'b0;
         error_o        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (word_write_strobe_i) begin
                  if (hdr_ok) begin
                     shadow_col  <= CW'(write_data_i[23:16]);
                     shadow_idx  <= IW'(write_data_i[7:0]);
                     shadow_data <= '0;
                     row_cnt     <= '0;
                     idle_cnt    <= '0;
                     xor_acc     <= write_data_i;
                     state       <= S_LOAD;
                  end else begin
                     error_o <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               if (word_write_strobe_i) begin
                  idle_cnt    <= '0;
                  shadow_data <= shifted_data;
                  xor_acc     <= xor_acc ^ write_data_i;
                  if (row_cnt == LAST_ROW) begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
                     state <= S_CHECK;
`else
                     // Commit straight from the shift path so no extra cycle is spent.
                     frame_data_o   <= shifted_data;
                     frame_col_o    <= shadow_col;
                     frame_idx_o    <= shadow_idx;
                     frame_strobe_o <= 1'b1;
                     state          <= S_IDLE;
`endif
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end else if (timed_out) begin
                  error_o <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

            S_CHECK: begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
               if (word_write_strobe_i) begin
                  idle_cnt <= '0;
                  if (write_data_i == xor_acc) begin
                     frame_data_o   <= shadow_data;
                     frame_col_o    <= shadow_col;
                     frame_idx_o    <= shadow_idx;
                     frame_strobe_o <= 1'b1;
                  end else begin
                     error_o <= 1'b1;
                  end
                  state <= S_IDLE;
               end else if (timed_out) begin
                  error_o <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
`else
               state <= S_IDLE;
`endif
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_config_frame_assembler.sv
// Directed bench for config_frame_assembler (NUM_ROWS=4, 16 columns,
// 20 frames/column, TIMEOUT_CYCLES=8).
module tb_config_frame_assembler;

   localparam int FW = 128;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          word_write_strobe_i = 1'b0;
   logic [31:0]   write_data_i = '0;
   logic          frame_strobe_o;
   logic [FW-1:0] frame_data_o;
   logic [3:0]    frame_col_o;
   logic [4:0]    frame_idx_o;
   logic          busy_o;
   logic          error_o;
   logic [1:0]    state_o;

   int total = 0;
   int bad = 0;
   int strobe_seen = 0;
   int strobe_exp = 0;
   logic [FW-1:0] exp_q[$];

   config_frame_assembler #(
      .NUM_ROWS(4), .NUM_COLUMNS(16), .FRAMES_PER_COL(20), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .word_write_strobe_i(word_write_strobe_i), .write_data_i(write_data_i),
      .frame_strobe_o(frame_strobe_o), .frame_data_o(frame_data_o),
      .frame_col_o(frame_col_o), .frame_idx_o(frame_idx_o),
      .busy_o(busy_o), .error_o(error_o), .state_o(state_o)
   );

   // clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, got timeout, need finish");
      $fatal(1, "watchdog");
   end

   // strobe monitor, sampled away from the active edge
   always @(negedge clk_i) if (frame_strobe_o) strobe_seen++;

   // checking task
   task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h need %0h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change #1 after the edge, outputs read there too
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_word(input logic [31:0] w);
      word_write_strobe_i = 1'b1;
      write_data_i = w;
      tick();
      word_write_strobe_i = 1'b0;
      write_data_i = '0;
   endtask

   task automatic send_frame(input logic [31:0] hdr, input logic [FW-1:0] data);
      logic [31:0] x;
      x = hdr;
      send_word(hdr);
      for (int i = 3; i >= 0; i--) begin
         x = x ^ data[i*32 +: 32];
         send_word(data[i*32 +: 32]);
      end
`ifdef CONFIG_FRAME_CHECKSUM_EN
      send_word(x);
`endif
   endtask

   task automatic expect_commit(input string tag, input logic [3:0] col, input logic [4:0] idx);
      logic [FW-1:0] e;
      e = exp_q.pop_front();
      strobe_exp++;
      chk({tag, "_strobe"}, FW'(frame_strobe_o), FW'(1));
      chk({tag, "_data"},   frame_data_o, e);
      chk({tag, "_col"},    FW'(frame_col_o), FW'(col));
      chk({tag, "_idx"},    FW'(frame_idx_o), FW'(idx));
      chk({tag, "_err"},    FW'(error_o), FW'(0));
      chk({tag, "_busy"},   FW'(busy_o), FW'(0));
   endtask

   localparam logic [FW-1:0] D1 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [FW-1:0] D2 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
   localparam logic [FW-1:0] D3 = 128'h00000001_00000002_00000003_00000004;
   localparam logic [FW-1:0] D4 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   localparam logic [FW-1:0] D5 = 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0;
   localparam logic [FW-1:0] D6 = 128'h01020304_10203040_A5A5A5A5_0000FFFF;

   initial begin
      // reset
      reset_i = 1'b1;
      idle(3);
      chk("rst_data", frame_data_o, '0);
      chk("rst_col", FW'(frame_col_o), '0);
      chk("rst_idx", FW'(frame_idx_o), '0);
      chk("rst_strobe", FW'(frame_strobe_o), '0);
      chk("rst_busy", FW'(busy_o), '0);
      chk("rst_err", FW'(error_o), '0);
      reset_i = 1'b0;
      idle(2);

      // basic frame
      exp_q.push_back(D1);
      send_frame(32'hFA03_0005, D1);
      expect_commit("t1", 4'd3, 5'd5);
      tick();
      chk("t1_strobe_1cyc", FW'(frame_strobe_o), '0);
      chk("t1_hold", frame_data_o, D1);

      // bad headers: marker, column boundary, frame boundary
      send_word(32'hFB00_0000);
      chk("t2_marker_err", FW'(error_o), FW'(1));
      chk("t2_marker_busy", FW'(busy_o), '0);
      tick();
      chk("t2_err_1cyc", FW'(error_o), '0);
      send_word(32'hFA10_0000);
      chk("t2_col_err", FW'(error_o), FW'(1));
      chk("t2_col_busy", FW'(busy_o), '0);
      send_word(32'hFA00_0014);
      chk("t2_idx_err", FW'(error_o), FW'(1));
      chk("t2_idx_busy", FW'(busy_o), '0);
      chk("t2_hold", frame_data_o, D1);
      exp_q.push_back(D2);
      send_frame(32'hFA0F_0013, D2);
      expect_commit("t2", 4'd15, 5'd19);

      // timeout after two data words
      tick();
      send_word(32'hFA01_0002);
      send_word(32'h0BAD0001);
      send_word(32'h0BAD0002);
      idle(7);
      chk("t3_busy_pre", FW'(busy_o), FW'(1));
      chk("t3_err_pre", FW'(error_o), '0);
      idle(1);
      chk("t3_err", FW'(error_o), FW'(1));
      chk("t3_busy", FW'(busy_o), '0);
      chk("t3_hold_data", frame_data_o, D2);
      chk("t3_hold_col", FW'(frame_col_o), FW'(15));
      exp_q.push_back(D3);
      send_frame(32'hFA02_0001, D3);
      expect_commit("t3", 4'd2, 5'd1);

      // back-to-back: second header lands in the strobe cycle
      tick();
      exp_q.push_back(D4);
      send_frame(32'hFA07_000A, D4);
      expect_commit("t4a", 4'd7, 5'd10);
      exp_q.push_back(D5);
      send_frame(32'hFA0C_0000, D5);
      expect_commit("t4b", 4'd12, 5'd0);

      // reset in the middle of a frame
      tick();
      send_word(32'hFA05_0003);
      send_word(32'h55555555);
      send_word(32'h66666666);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("t5_data", frame_data_o, '0);
      chk("t5_col", FW'(frame_col_o), '0);
      chk("t5_idx", FW'(frame_idx_o), '0);
      chk("t5_busy", FW'(busy_o), '0);
      chk("t5_strobe", FW'(frame_strobe_o), '0);
      exp_q.push_back(D1);
      send_frame(32'hFA03_0005, D1);
      expect_commit("t5", 4'd3, 5'd5);

`ifdef CONFIG_FRAME_CHECKSUM_EN
      // checksum: good word commits, flipped word is rejected
      tick();
      send_word(32'hFA04_0007);
      for (int i = 3; i >= 0; i--) send_word(D6[i*32 +: 32]);
      chk("t6_wait_busy", FW'(busy_o), FW'(1));
      chk("t6_wait_strobe", FW'(frame_strobe_o), '0);
      exp_q.push_back(D6);
      send_word(32'h4E83_6919);
      expect_commit("t6", 4'd4, 5'd7);
      tick();
      send_word(32'hFA04_0007);
      for (int i = 3; i >= 0; i--) send_word(D6[i*32 +: 32]);
      send_word(32'h4E83_6918);
      chk("t6_bad_err", FW'(error_o), FW'(1));
      chk("t6_bad_strobe", FW'(frame_strobe_o), '0);
      chk("t6_bad_busy", FW'(busy_o), '0);
      chk("t6_bad_hold", frame_data_o, D6);
`endif

      idle(3);
      chk("strobe_count", FW'(strobe_seen), FW'(strobe_exp));
      chk("queue_empty", FW'(exp_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
